// File: rtl/cpu_mem_responder.sv
// Word memory behind the CPU fetch, load and store ports, with a boot-stream
// loader that fills the array from address 0 before releasing the CPU.
module cpu_mem_responder #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read_mem_ir,
  input  logic [ADDR_W-1:0] mem_radrs_ir,
  output logic [DATA_W-1:0] instruction_fetch,
  input  logic              read_mem_str,
  input  logic [ADDR_W-1:0] mem_radrs_ld,
  output logic [DATA_W-1:0] mem_store_data,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_wadrs,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_run,
  output logic [ADDR_W:0]   boot_words
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ld_q, ld_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              run;
  logic              hs;

  assign run = (state_q == RUN);
  assign hs  = !run && ld_valid && ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    ld_d    = ld_q;
    we      = 1'b0;
    wa      = mem_wadrs;
    wd      = mem_wdata;
    unique case (state_q)
      BOOT: begin
        if (hs) begin
          we    = 1'b1;
          wa    = ptr_q;
          wd    = ld_data;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (ld_last || ptr_q == LAST)
            state_d = RUN;
        end
      end
      RUN: begin
        we = write_mem;
        // Write-first: a same-cycle store to the read address wins.
        if (read_mem_ir)
          ir_d = (write_mem && mem_wadrs == mem_radrs_ir)
               ? mem_wdata : mem_q[mem_radrs_ir];
        if (read_mem_str)
          ld_d = (write_mem && mem_wadrs == mem_radrs_ld)
               ? mem_wdata : mem_q[mem_radrs_ld];
      end
      default: state_d = BOOT;
    endcase
    ready_d = (state_d == BOOT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= BOOT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ir_q    <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ir_q    <= ir_d;
      ld_q    <= ld_d;
    end
  end

  // Array is never cleared; reset only blocks a write on the reset edge.
  always_ff @(posedge clk) begin
    if (resetn && we)
      mem_q[wa] <= wd;
  end

  assign instruction_fetch = ir_q;
  assign mem_store_data    = ld_q;
  assign ld_ready          = ready_q;
  assign cpu_run           = run;
  assign boot_words        = cnt_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: read data is checked by a monitor
// against queued expectations; status outputs are checked inline.
module tb_cpu_mem_responder;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          read_mem_ir = 1'b0;
  logic [AW-1:0] mem_radrs_ir = '0;
  logic [DW-1:0] instruction_fetch;
  logic          read_mem_str = 1'b0;
  logic [AW-1:0] mem_radrs_ld = '0;
  logic [DW-1:0] mem_store_data;
  logic          write_mem = 1'b0;
  logic [AW-1:0] mem_wadrs = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          cpu_run;
  logic [AW:0]   boot_words;

  cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2048)) dut (
    .clk(clk), .resetn(resetn),
    .read_mem_ir(read_mem_ir), .mem_radrs_ir(mem_radrs_ir),
    .instruction_fetch(instruction_fetch),
    .read_mem_str(read_mem_str), .mem_radrs_ld(mem_radrs_ld),
    .mem_store_data(mem_store_data),
    .write_mem(write_mem), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_run(cpu_run), .boot_words(boot_words)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] ir_exp[$];
  logic [DW-1:0] ld_exp[$];
  logic ir_pend = 1'b0;
  logic ld_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic boot_word(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e);
    read_mem_ir  = 1'b1;
    mem_radrs_ir = a;
    ir_exp.push_back(e);
    tick();
    read_mem_ir = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // A read issued while running presents data after the next edge.
  always @(posedge clk) begin
    ir_pend <= resetn && cpu_run && read_mem_ir;
    ld_pend <= resetn && cpu_run && read_mem_str;
  end

  always @(negedge clk) begin
    if (ir_pend) begin
      if (ir_exp.size() == 0) begin
        total++;
        $display("FAIL ir_unexpected: got %h expected none", instruction_fetch);
      end else
        chk("ir_data", instruction_fetch, ir_exp.pop_front());
    end
    if (ld_pend) begin
      if (ld_exp.size() == 0) begin
        total++;
        $display("FAIL ld_unexpected: got %h expected none", mem_store_data);
      end else
        chk("ld_data", mem_store_data, ld_exp.pop_front());
    end
  end

  initial begin
    // Reset values
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_boot_words", 32'(boot_words), 0);
    chk("rst_ifetch", instruction_fetch, 0);
    chk("rst_ldata", mem_store_data, 0);
    resetn = 1'b1;
    tick();
    chk("boot_ready", 32'(ld_ready), 1);

    // Test 1: three-word boot then fetch
    boot_word(32'hA0, 1'b0);
    boot_word(32'hA1, 1'b0);
    chk("t1_run_before_last", 32'(cpu_run), 0);
    chk("t1_ifetch_boot", instruction_fetch, 0);
    boot_word(32'hA2, 1'b1);
    chk("t1_cpu_run", 32'(cpu_run), 1);
    chk("t1_ld_ready", 32'(ld_ready), 0);
    chk("t1_boot_words", 32'(boot_words), 3);
    fetch(0, 32'hA0);
    fetch(1, 32'hA1);
    fetch(2, 32'hA2);
    tick();
    chk("t1_hold", instruction_fetch, 32'hA2);

    // Test 2: store then load on the next cycle
    write_mem = 1'b1;
    mem_wadrs = 11'h10;
    mem_wdata = 32'hDEADBEEF;
    tick();
    write_mem    = 1'b0;
    read_mem_str = 1'b1;
    mem_radrs_ld = 11'h10;
    ld_exp.push_back(32'hDEADBEEF);
    tick();
    read_mem_str = 1'b0;

    // Test 3: read-during-write on both ports
    write_mem    = 1'b1;
    mem_wadrs    = 11'h20;
    mem_wdata    = 32'h55;
    read_mem_str = 1'b1;
    mem_radrs_ld = 11'h20;
    read_mem_ir  = 1'b1;
    mem_radrs_ir = 11'h20;
    ld_exp.push_back(32'h55);
    ir_exp.push_back(32'h55);
    tick();
    write_mem    = 1'b0;
    read_mem_str = 1'b0;
    read_mem_ir  = 1'b0;
    tick();
    chk("t3_ld_hold", mem_store_data, 32'h55);

    // Test 5: reset mid-boot, then reload three words
    do_reset();
    for (int i = 0; i < 5; i++)
      boot_word(32'hB0 + 32'(i), 1'b0);
    chk("t5_mid_words", 32'(boot_words), 5);
    resetn = 1'b0;
    tick();
    chk("t5_rst_words", 32'(boot_words), 0);
    chk("t5_rst_run", 32'(cpu_run), 0);
    resetn = 1'b1;
    tick();
    boot_word(32'hC0, 1'b0);
    boot_word(32'hC1, 1'b0);
    chk("t5_run_before_last", 32'(cpu_run), 0);
    boot_word(32'hC2, 1'b1);
    chk("t5_cpu_run", 32'(cpu_run), 1);
    chk("t5_boot_words", 32'(boot_words), 3);
    fetch(0, 32'hC0);
    fetch(1, 32'hC1);
    fetch(2, 32'hC2);
    fetch(3, 32'hB3);
    fetch(4, 32'hB4);

    // Test 6: boot stream ignored while running
    for (int k = 0; k < 4; k++) begin
      ld_valid = k[0] ? 1'b0 : 1'b1;
      ld_data  = 32'hFFFF0000 + 32'(k);
      tick();
      chk("t6_ld_ready", 32'(ld_ready), 0);
    end
    ld_valid = 1'b0;
    chk("t6_boot_words", 32'(boot_words), 3);
    fetch(3, 32'hB3);
    fetch(4, 32'hB4);
    fetch(0, 32'hC0);

    // Test 4: fill the whole array with no last marker
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      if (i == 2047) begin
        chk("t4_ready_last", 32'(ld_ready), 1);
        chk("t4_run_last", 32'(cpu_run), 0);
      end
      boot_word(32'h10000000 + 32'(i), 1'b0);
    end
    chk("t4_ld_ready", 32'(ld_ready), 0);
    chk("t4_cpu_run", 32'(cpu_run), 1);
    chk("t4_boot_words", 32'(boot_words), 2048);
    fetch(11'd2047, 32'h100007FF);
    fetch(11'd0, 32'h10000000);
    fetch(11'd1024, 32'h10000400);

    tick();
    tick();
    chk("sb_drain", 32'(ir_exp.size() + ld_exp.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
